fifo_rd_ptr_ctrl: RTL
=====================

// Module: fifo_rd_ptr_ctrl
// PURPOSE
//  Read-side pointer controller for the dual-clock Ethernet FIFO, in the read clock domain.
//  - Synchronises the gray write pointer internally.
//  - Generates empty, almost-empty (runtime threshold), fill level and an underflow flag.
//  - Adds frame-level commit/rewind: the MAC TX path can re-read a frame after a collision.
//  - Only committed space is published to the write domain.
// PARAMETERS
//  ADDR_WIDTH         9  memory address bits; pointers are ADDR_WIDTH+1 bits
//  SYNC_STAGES        2  flops in the w_ptr synchroniser, min 2
//  PACKET_MODE        0  1 = commit/rewind active; 0 = every read commits immediately
// PORTS
//  clk            in   1             read-domain clock
//  reset          in   1             asynchronous, active-high reset
//  read           in   1             read request; honoured only when !empty
//  rd_commit      in   1             frame done: release frame space to the writer (PACKET_MODE=1)
//  rd_rewind      in   1             re-read from the last commit point (PACKET_MODE=1)
//  ae_thresh      in   ADDR_WIDTH+1  almost-empty threshold, in words
//  underflow_clr  in   1             clears the sticky underflow flag
//  w_ptr          in   ADDR_WIDTH+1  gray write pointer from the write domain, unsynchronised
//  rd_addr        out  ADDR_WIDTH    binary memory address = spec_ptr[ADDR_WIDTH-1:0]
//  rd_ptr         out  ADDR_WIDTH+1  gray committed pointer, to the write domain
//  empty          out  1             no unread words after the speculative pointer
//  almost_empty   out  1             level <= ae_thresh
//  level          out  ADDR_WIDTH+1  words available to read
//  underflow      out  1             sticky: read asserted while empty
// BEHAVIOUR
//  Reset (async assert, sync-to-clk release):
//   - synchroniser flops, spec_ptr, cmt_ptr, rd_ptr and level = 0.
//   - empty = 1, almost_empty = 1, underflow = 0.
//  Synchroniser and conversion:
//   - w_ptr passes through SYNC_STAGES flops; the output is gray-to-binary converted to wr_bin.
//   - A w_ptr change is reflected in empty/level SYNC_STAGES+1 clocks later.
//  Pointer update (all arithmetic is ADDR_WIDTH+1 bits, wraps modulo 2^(ADDR_WIDTH+1)):
//   - rd_en = read & !empty.
//   - spec_nxt = rewind_eff ? cmt_ptr : spec_ptr + rd_en.
//   - cmt_nxt  = commit_eff ? (spec_ptr + rd_en) : cmt_ptr.
//  Mode rules:
//   - PACKET_MODE=0: rewind_eff = 0, commit_eff = 1, so cmt_ptr tracks spec_ptr each cycle.
//   - PACKET_MODE=1: rewind_eff = rd_rewind, commit_eff = rd_commit & !rd_rewind.
//   - Rewind wins over a simultaneous commit.
//   - A read in a rewind cycle is discarded; rd_addr is still presented but not consumed.
//  Registered outputs, 1-cycle latency from the spec_nxt/cmt_nxt computation:
//   - empty        <= (spec_nxt == wr_bin).
//   - level        <= wr_bin - spec_nxt.
//   - almost_empty <= ((wr_bin - spec_nxt) <= ae_thresh).
//   - rd_ptr       <= bin2gray(cmt_nxt).
//  Flags and thresholds:
//   - underflow is set when read & empty; cleared by underflow_clr; set wins if both occur.
//   - ae_thresh is sampled every cycle; a change takes effect on the next registered almost_empty.
//   - ae_thresh >= 2^ADDR_WIDTH forces almost_empty = 1.
//  Wrap: the MSB toggles each pass; level stays correct across wrap, max 2^ADDR_WIDTH.
//  Full FIFO (level = 2^ADDR_WIDTH): empty = 0, reads proceed normally.
//  rd_rewind with spec_ptr == cmt_ptr: no change. rd_commit with no reads since the last commit: no change.
// TESTING (ADDR_WIDTH=4, SYNC_STAGES=2)
//  1 Reset: assert reset mid-stream with level=5 -> immediately empty=1, level=0, rd_ptr=0, underflow=0.
//  2 Latency: w_ptr gray 0->1 at cycle 0 -> empty falls and level=1 at cycle 3.
//  3 Almost-empty: w_ptr=bin 6, ae_thresh=3; read 3 words -> almost_empty rises when level=3.
//    Then set ae_thresh=1 -> almost_empty falls next cycle.
//  4 Wrap: write 16, read 16, repeated 3 passes -> rd_addr wraps 15->0, rd_ptr MSB toggles.
//    level peaks at 16 with empty=0.
//  5 PACKET_MODE=1: read 5 words, rd_rewind -> rd_addr returns to 0, rd_ptr unchanged at 0.
//    Re-read 5 and pulse rd_commit with the 5th read -> rd_ptr=gray(5)=0x07.
//    Pulsing rd_commit and rd_rewind together -> rd_ptr unchanged.
//  6 Underflow: read while empty -> spec_ptr unchanged, underflow=1 next cycle and held.
//    underflow_clr -> underflow=0. clr together with an empty read -> underflow stays 1.

Source files
------------

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for the dual-clock Ethernet FIFO.
// Speculative read pointer with frame commit/rewind; committed pointer goes to the writer.
module fifo_rd_ptr_ctrl #(
  parameter int ADDR_WIDTH  = 9,
  parameter int SYNC_STAGES = 2,
  parameter int PACKET_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  rd_commit,
  input  logic                  rd_rewind,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  underflow_clr,
  input  logic [ADDR_WIDTH:0]   w_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam bit PM = (PACKET_MODE != 0);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] spec_ptr;
  logic [PW-1:0] cmt_ptr;
  logic [PW-1:0] spec_inc;
  logic [PW-1:0] spec_nxt;
  logic [PW-1:0] cmt_nxt;
  logic [PW-1:0] avail;
  logic          rd_en;
  logic          rewind_eff;
  logic          commit_eff;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= w_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_bin = gray2bin(sync_q[SYNC_STAGES-1]);

  // Rewind beats commit; without packet mode every read commits at once.
  assign rewind_eff = PM ? rd_rewind : 1'b0;
  assign commit_eff = PM ? (rd_commit & ~rd_rewind) : 1'b1;

  assign rd_en    = read & ~empty;
  assign spec_inc = spec_ptr + {{ADDR_WIDTH{1'b0}}, rd_en};
  assign spec_nxt = rewind_eff ? cmt_ptr : spec_inc;
  assign cmt_nxt  = commit_eff ? spec_inc : cmt_ptr;
  assign avail    = wr_bin - spec_nxt;
  assign rd_addr  = spec_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_ptr     <= '0;
      cmt_ptr      <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      spec_ptr     <= spec_nxt;
      cmt_ptr      <= cmt_nxt;
      rd_ptr       <= bin2gray(cmt_nxt);
      level        <= avail;
      empty        <= (spec_nxt == wr_bin);
      // A threshold of a full memory or more always reads as almost empty.
      almost_empty <= (avail <= ae_thresh) | ae_thresh[PW-1];
      underflow    <= (read & empty) | (underflow & ~underflow_clr);
    end
  end

endmodule
